// File: rtl/cv32e40p_apu_arbiter_if.sv
// Bundle of core-side and APU-side signals of the shared-APU arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment (cores plus APU) driving it.
interface cv32e40p_apu_arbiter_if #(
  parameter int unsigned NUM_CORES        = 2,
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NDSFLAGS_CPU = 15,
  parameter int unsigned APU_NUSFLAGS_CPU = 5
);

  // core side
  logic [NUM_CORES-1:0]                    core_apu_req_i;
  logic [NUM_CORES-1:0]                    core_apu_gnt_o;
  logic [NUM_CORES*APU_NARGS_CPU*32-1:0]   core_apu_operands_i;
  logic [NUM_CORES*APU_WOP_CPU-1:0]        core_apu_op_i;
  logic [NUM_CORES*APU_NDSFLAGS_CPU-1:0]   core_apu_flags_i;
  logic [NUM_CORES-1:0]                    core_apu_rvalid_o;
  logic [31:0]                             core_apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]             core_apu_flags_o;

  // shared APU side
  logic                                    apu_req_o;
  logic                                    apu_gnt_i;
  logic [APU_NARGS_CPU*32-1:0]             apu_operands_o;
  logic [APU_WOP_CPU-1:0]                  apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]             apu_flags_o;
  logic                                    apu_rvalid_i;
  logic [31:0]                             apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]             apu_flags_i;

  logic                                    resp_err_o;

  modport slave (
    input  core_apu_req_i, core_apu_operands_i, core_apu_op_i, core_apu_flags_i,
    input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    output core_apu_gnt_o, core_apu_rvalid_o, core_apu_result_o, core_apu_flags_o,
    output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o, resp_err_o
  );

  modport master (
    output core_apu_req_i, core_apu_operands_i, core_apu_op_i, core_apu_flags_i,
    output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_flags_i,
    input  core_apu_gnt_o, core_apu_rvalid_o, core_apu_result_o, core_apu_flags_o,
    input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o, resp_err_o
  );

endinterface

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU between NUM_CORES cores. Grants and
// responses are routed combinationally; an in-order tag FIFO remembers which
// core issued each outstanding operation.
module cv32e40p_apu_arbiter #(
  parameter int unsigned NUM_CORES        = 2,
  parameter int unsigned APU_NARGS_CPU    = 3,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NDSFLAGS_CPU = 15,
  parameter int unsigned APU_NUSFLAGS_CPU = 5,
  parameter int unsigned MAX_OUTSTANDING  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  cv32e40p_apu_arbiter_if.slave    bus
);

  localparam int unsigned IDW = $clog2(NUM_CORES);
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned OPW = APU_NARGS_CPU * 32;

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  lock_id;
  logic [IDW-1:0]  rr_sel;
  logic [IDW-1:0]  sel;

  logic [IDW-1:0]  tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            fifo_full;
  logic            fifo_empty;
  logic            rst_q;
  logic            out_block;
  logic            push;
  logic            pop;
  logic            resp_err;

  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);
  // Outputs stay quiet during reset and for one cycle after it.
  assign out_block  = rst_i | rst_q;

  // Rotating-priority search starting at rr_ptr.
  always_comb begin
    logic        found;
    int unsigned idx;
    found  = 1'b0;
    idx    = 0;
    rr_sel = rr_ptr;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_CORES;
      if (!found && bus.core_apu_req_i[IDW'(idx)]) begin
        rr_sel = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Request, grant, response routing and payload mux.
  always_comb begin
    sel           = (state == WAIT_GNT) ? lock_id : rr_sel;
    bus.apu_req_o = !out_block &&
                    ((state == WAIT_GNT) || ((|bus.core_apu_req_i) && !fifo_full));
    push          = bus.apu_req_o & bus.apu_gnt_i;
    pop           = bus.apu_rvalid_i & !fifo_empty & !out_block;

    bus.core_apu_gnt_o         = '0;
    bus.core_apu_gnt_o[sel]    = push;
    bus.core_apu_rvalid_o      = '0;
    bus.core_apu_rvalid_o[tag_mem[rd_ptr]] = pop;
    bus.core_apu_result_o      = bus.apu_result_i;
    bus.core_apu_flags_o       = bus.apu_flags_i;

    bus.apu_operands_o = '0;
    bus.apu_op_o       = '0;
    bus.apu_flags_o    = '0;
    if (bus.apu_req_o) begin
      bus.apu_operands_o = bus.core_apu_operands_i[32'(sel)*OPW +: OPW];
      bus.apu_op_o       = bus.core_apu_op_i[32'(sel)*APU_WOP_CPU +: APU_WOP_CPU];
      bus.apu_flags_o    = bus.core_apu_flags_i[32'(sel)*APU_NDSFLAGS_CPU +: APU_NDSFLAGS_CPU];
    end
  end

  assign bus.resp_err_o = resp_err;

  // Arbitration FSM: lock the selected core while the APU withholds its grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.apu_gnt_i && bus.apu_req_o) begin
            lock_id <= sel;
            state   <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (bus.apu_gnt_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push) begin
        rr_ptr <= (32'(sel) == NUM_CORES - 1) ? '0 : sel + 1'b1;
      end
    end
  end

  // Tag storage; contents are only meaningful between write and read pointers.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (32'(wr_ptr) == MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (32'(rd_ptr) == MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Reset tracker and sticky error for responses with nothing outstanding.
  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      resp_err <= 1'b0;
    end else if (bus.apu_rvalid_i && fifo_empty) begin
      resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed bench for the shared-APU arbiter; a negedge monitor checks grants
// and routed responses against scoreboard queues filled by the stimulus.
module tb_cv32e40p_apu_arbiter;

  localparam int unsigned NC   = 2;
  localparam int unsigned NARG = 3;
  localparam int unsigned WOP  = 6;
  localparam int unsigned NDS  = 15;
  localparam int unsigned NUS  = 5;
  localparam int unsigned MO   = 2;

  localparam logic [95:0] OPS0 = 96'hA0000002_A0000001_A0000000;
  localparam logic [95:0] OPS1 = 96'hB0000002_B0000001_B0000000;
  localparam logic [5:0]  OP0  = 6'h11;
  localparam logic [5:0]  OP1  = 6'h22;

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] r;
    logic [4:0]  f;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] gq[$];
  rsp_t       rq[$];
  logic [1:0] g_exp;
  rsp_t       r_exp;
  rsp_t       r_act;

  always #5 clk = ~clk;

  cv32e40p_apu_arbiter_if #(
    .NUM_CORES(NC), .APU_NARGS_CPU(NARG), .APU_WOP_CPU(WOP),
    .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS)
  ) bus ();

  cv32e40p_apu_arbiter #(
    .NUM_CORES(NC), .APU_NARGS_CPU(NARG), .APU_WOP_CPU(WOP),
    .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  function automatic rsp_t mk_rsp(input logic [1:0] v, input logic [31:0] r,
                                  input logic [4:0] f);
    rsp_t t;
    t.v = v; t.r = r; t.f = f;
    return t;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reset with active inputs; outputs must stay low. Returns in the first
  // cycle after release, where outputs are still blocked.
  task automatic do_reset();
    rst_i = 1'b1;
    bus.core_apu_req_i = 2'b11;
    bus.apu_gnt_i      = 1'b1;
    bus.apu_rvalid_i   = 1'b1;
    cyc();
    cyc();
    settle();
    chk("rst_gnt",    bus.core_apu_gnt_o, 2'b00);
    chk("rst_rvalid", bus.core_apu_rvalid_o, 2'b00);
    chk("rst_req",    bus.apu_req_o, 1'b0);
    chk("rst_err",    bus.resp_err_o, 1'b0);
    chk("rst_op",     bus.apu_op_o, 6'h00);
    cyc();
    rst_i = 1'b0;
    bus.core_apu_req_i = 2'b00;
    bus.apu_gnt_i      = 1'b0;
    bus.apu_rvalid_i   = 1'b0;
  endtask

  // Monitor: every grant and every routed response must match the next
  // scoreboard entry.
  always @(negedge clk) begin
    if (bus.core_apu_gnt_o != 2'b00) begin
      n_checks++;
      if (gq.size() == 0) begin
        n_fail++;
        $display("FAIL grant_unexpected: got %b expected none", bus.core_apu_gnt_o);
      end else begin
        g_exp = gq.pop_front();
        if (bus.core_apu_gnt_o !== g_exp) begin
          n_fail++;
          $display("FAIL grant_order: got %b expected %b", bus.core_apu_gnt_o, g_exp);
        end
      end
    end
    if (bus.core_apu_rvalid_o != 2'b00) begin
      n_checks++;
      r_act = mk_rsp(bus.core_apu_rvalid_o, bus.core_apu_result_o, bus.core_apu_flags_o);
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexpected: got %0h expected none", r_act);
      end else begin
        r_exp = rq.pop_front();
        if (r_act !== r_exp) begin
          n_fail++;
          $display("FAIL response_route: got v=%b r=%h f=%h expected v=%b r=%h f=%h",
                   r_act.v, r_act.r, r_act.f, r_exp.v, r_exp.r, r_exp.f);
        end
      end
    end
  end

  initial begin
    bus.core_apu_operands_i = {OPS1, OPS0};
    bus.core_apu_op_i       = {OP1, OP0};
    bus.core_apu_flags_i    = {15'h0202, 15'h0101};
    bus.core_apu_req_i      = 2'b00;
    bus.apu_gnt_i           = 1'b0;
    bus.apu_rvalid_i        = 1'b0;
    bus.apu_result_i        = 32'h0;
    bus.apu_flags_i         = 5'h0;

    // single core request, immediate grant, later response
    do_reset();
    bus.core_apu_req_i = 2'b01;
    bus.apu_gnt_i      = 1'b1;
    settle();
    chk("post_reset_req", bus.apu_req_o, 1'b0);
    chk("post_reset_gnt", bus.core_apu_gnt_o, 2'b00);
    cyc();
    gq.push_back(2'b01);
    settle();
    chk("s1_op", bus.apu_op_o, OP0);
    chk("s1_operands", bus.apu_operands_o, OPS0);
    chk("s1_flags", bus.apu_flags_o, 15'h0101);
    cyc();
    bus.core_apu_req_i = 2'b00;
    bus.apu_gnt_i      = 1'b0;
    settle();
    chk("s1_idle_req", bus.apu_req_o, 1'b0);
    chk("s1_idle_op", bus.apu_op_o, 6'h00);
    cyc();
    bus.apu_rvalid_i = 1'b1;
    bus.apu_result_i = 32'h3F800000;
    bus.apu_flags_i  = 5'h03;
    rq.push_back(mk_rsp(2'b01, 32'h3F800000, 5'h03));
    settle();
    cyc();
    bus.apu_rvalid_i = 1'b0;

    // both cores requesting, APU always granting, responses one cycle later
    do_reset();
    cyc();
    bus.core_apu_req_i = 2'b11;
    bus.apu_gnt_i      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gq.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        bus.apu_rvalid_i = 1'b1;
        bus.apu_result_i = 32'h10000000 + 32'(i - 1);
        bus.apu_flags_i  = 5'(i - 1);
        rq.push_back(mk_rsp(((i - 1) % 2 == 0) ? 2'b01 : 2'b10,
                            32'h10000000 + 32'(i - 1), 5'(i - 1)));
      end
      settle();
      chk("s2_op", bus.apu_op_o, (i % 2 == 0) ? OP0 : OP1);
      cyc();
    end
    bus.core_apu_req_i = 2'b00;
    bus.apu_gnt_i      = 1'b0;
    bus.apu_rvalid_i   = 1'b1;
    bus.apu_result_i   = 32'h10000003;
    bus.apu_flags_i    = 5'h03;
    rq.push_back(mk_rsp(2'b10, 32'h10000003, 5'h03));
    settle();
    cyc();
    bus.apu_rvalid_i = 1'b0;

    // core 1 waits for the APU grant; core 0 arriving later must not steal it
    bus.core_apu_req_i = 2'b10;
    settle();
    chk("s3_req", bus.apu_req_o, 1'b1);
    chk("s3_op_a", bus.apu_op_o, OP1);
    cyc();
    settle();
    chk("s3_op_b", bus.apu_op_o, OP1);
    cyc();
    bus.core_apu_req_i = 2'b11;
    settle();
    chk("s3_lock_op", bus.apu_op_o, OP1);
    chk("s3_lock_operands", bus.apu_operands_o, OPS1);
    cyc();
    bus.apu_gnt_i = 1'b1;
    gq.push_back(2'b10);
    settle();
    cyc();
    bus.core_apu_req_i = 2'b01;
    gq.push_back(2'b01);
    settle();
    chk("s3_next_op", bus.apu_op_o, OP0);
    cyc();

    // FIFO now holds two outstanding tags (core 1, core 0)
    settle();
    chk("s4_full_req", bus.apu_req_o, 1'b0);
    cyc();
    bus.apu_rvalid_i = 1'b1;
    bus.apu_result_i = 32'hA1A1A1A1;
    bus.apu_flags_i  = 5'h01;
    rq.push_back(mk_rsp(2'b10, 32'hA1A1A1A1, 5'h01));
    settle();
    chk("s4_full_pop_req", bus.apu_req_o, 1'b0);
    cyc();
    bus.apu_rvalid_i = 1'b0;
    gq.push_back(2'b01);
    settle();
    chk("s4_reissue_req", bus.apu_req_o, 1'b1);
    cyc();
    bus.core_apu_req_i = 2'b00;
    bus.apu_gnt_i      = 1'b0;
    bus.apu_rvalid_i   = 1'b1;
    bus.apu_result_i   = 32'hA2A2A2A2;
    bus.apu_flags_i    = 5'h02;
    rq.push_back(mk_rsp(2'b01, 32'hA2A2A2A2, 5'h02));
    settle();
    cyc();
    bus.apu_result_i = 32'hA3A3A3A3;
    bus.apu_flags_i  = 5'h04;
    rq.push_back(mk_rsp(2'b01, 32'hA3A3A3A3, 5'h04));
    settle();
    chk("s4_err_clean", bus.resp_err_o, 1'b0);
    cyc();
    bus.apu_rvalid_i = 1'b0;

    // stray response with nothing outstanding
    do_reset();
    cyc();
    bus.apu_rvalid_i = 1'b1;
    bus.apu_result_i = 32'hDEADBEEF;
    settle();
    chk("s5_no_rvalid", bus.core_apu_rvalid_o, 2'b00);
    chk("s5_err_not_yet", bus.resp_err_o, 1'b0);
    cyc();
    bus.apu_rvalid_i = 1'b0;
    settle();
    chk("s5_err_set", bus.resp_err_o, 1'b1);
    cyc();
    settle();
    chk("s5_err_sticky", bus.resp_err_o, 1'b1);
    cyc();

    // reset with two operations outstanding
    do_reset();
    cyc();
    bus.core_apu_req_i = 2'b11;
    bus.apu_gnt_i      = 1'b1;
    gq.push_back(2'b01);
    settle();
    cyc();
    gq.push_back(2'b10);
    settle();
    cyc();
    do_reset();
    settle();
    chk("s6_err_cleared", bus.resp_err_o, 1'b0);
    cyc();
    bus.apu_rvalid_i = 1'b1;
    bus.apu_result_i = 32'h12345678;
    settle();
    chk("s6_stray_no_rvalid", bus.core_apu_rvalid_o, 2'b00);
    cyc();
    bus.apu_rvalid_i   = 1'b0;
    bus.core_apu_req_i = 2'b11;
    bus.apu_gnt_i      = 1'b1;
    gq.push_back(2'b01);
    settle();
    chk("s6_err_set", bus.resp_err_o, 1'b1);
    chk("s6_fresh_op", bus.apu_op_o, OP0);
    cyc();
    bus.core_apu_req_i = 2'b00;
    bus.apu_gnt_i      = 1'b0;
    settle();
    cyc();

    chk("grants_drained", 128'(gq.size()), 128'd0);
    chk("responses_drained", 128'(rq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
